// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front end that turns MOSI frames into RAM command words and serialises read replies on MISO
module spi_slave_ctrl #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);
    localparam int CW = $clog2(FRAME_W + 1);
    localparam int MW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [FRAME_W-1:0] sh;
    logic [DATA_W-1:0]  txs;
    logic [MW-1:0]      mcnt;
    logic               seen;
    logic               replied;
    logic               done;
    logic               last;

    assign done = cnt == CW'(FRAME_W);
    assign last = cnt == CW'(FRAME_W - 1);

    // frame FSM: receive shift, command hand-off, read-reply serialiser; SS_n high aborts from any active state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            txs      <= '0;
            mcnt     <= '0;
            seen     <= 1'b0;
            replied  <= 1'b0;
            MISO     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state != IDLE && SS_n) begin
                state   <= IDLE;
                cnt     <= '0;
                sh      <= '0;
                txs     <= '0;
                mcnt    <= '0;
                replied <= 1'b0;
                MISO    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!SS_n) begin
                            state   <= CHK_CMD;
                            cnt     <= '0;
                            replied <= 1'b0;
                        end
                    end
                    CHK_CMD: begin
                        sh    <= FRAME_W'(MOSI);
                        cnt   <= CW'(1);
                        state <= !MOSI ? WRITE : seen ? READ_DATA : READ_ADD;
                    end
                    default: begin
                        if (!done) begin
                            sh  <= {sh[FRAME_W-2:0], MOSI};
                            cnt <= cnt + CW'(1);
                        end
                        if (last) begin
                            rx_data  <= {sh[FRAME_W-2:0], MOSI};
                            rx_valid <= 1'b1;
                            if (state == READ_ADD) seen <= 1'b1;
                        end
                        if (state == READ_DATA && done) begin
                            if (tx_valid && !replied) begin
                                MISO    <= tx_data[DATA_W-1];
                                txs     <= tx_data << 1;
                                mcnt    <= MW'(DATA_W - 1);
                                replied <= 1'b1;
                                seen    <= 1'b0;
                            end else if (mcnt != '0) begin
                                MISO <= txs[DATA_W-1];
                                txs  <= txs << 1;
                                mcnt <= mcnt - MW'(1);
                            end else begin
                                MISO <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: vector table, directed corner cases and randomized frames against a frame-level model
module tb_spi_slave_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       MISO;
    logic       rx_valid;
    logic [9:0] rx_data;
    int         tests = 0;
    int         fails = 0;

    spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] word;
        logic [7:0] td;
        int         dly;
        logic [9:0] exp_rx;
        logic       rep;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // inputs change on the falling edge; outputs are read on the following falling edge
    task automatic step(input logic ss, input logic mo, input logic tv, input logic [7:0] td);
        SS_n = ss;
        MOSI = mo;
        tx_valid = tv;
        tx_data = td;
        @(negedge clk);
    endtask

    // mode 0: no tx_valid, 1: random tx_valid noise, 2: tx_valid with 0xFF on every bit
    task automatic send(input logic [9:0] w, input logic [9:0] exp, input int n, input int mode);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 9; i >= 10 - n; i--) begin
            step(1'b0, w[i], mode == 2 ? 1'b1 : mode == 1 ? 1'($urandom) : 1'b0,
                 mode == 2 ? 8'hFF : 8'($urandom));
            chk("miso_rx", MISO, 0);
            if (i > 0) chk("rx_valid_mid", rx_valid, 0);
        end
        if (n == 10) begin
            chk("rx_valid_pulse", rx_valid, 1);
            chk("rx_data", rx_data, exp);
        end
    endtask

    task automatic reply(input logic [7:0] td, input logic [7:0] exp, input int dly, input bit noise);
        for (int d = 0; d < dly; d++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            chk("miso_wait", MISO, 0);
            if (d == 0) chk("rx_valid_drop", rx_valid, 0);
        end
        step(1'b0, 1'b0, 1'b1, td);
        for (int b = 7; b >= 0; b--) begin
            chk("miso_bit", MISO, exp[b]);
            step(1'b0, 1'b0, noise ? 1'($urandom) : 1'b0, 8'($urandom));
        end
        chk("miso_after", MISO, 0);
    endtask

    task automatic noreply();
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        chk("rx_valid_drop", rx_valid, 0);
        chk("miso_ignored", MISO, 0);
        step(1'b0, 1'b0, 1'b1, 8'h5A);
        chk("miso_ignored", MISO, 0);
    endtask

    task automatic end_frame();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rx_valid_end", rx_valid, 0);
        chk("miso_end", MISO, 0);
    endtask

    task automatic do_reset();
        SS_n = 1'b1;
        tx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_miso", MISO, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        tbl[0] = '{10'h0A5, 8'h00, 0, 10'h0A5, 1'b0, 8'h00};
        tbl[1] = '{10'h003, 8'h00, 0, 10'h003, 1'b0, 8'h00};
        tbl[2] = '{10'h1CC, 8'h00, 0, 10'h1CC, 1'b0, 8'h00};
        tbl[3] = '{10'h207, 8'h00, 0, 10'h207, 1'b0, 8'h00};
        tbl[4] = '{10'h3C3, 8'hB4, 3, 10'h3C3, 1'b1, 8'hB4};
        tbl[5] = '{10'h001, 8'h00, 0, 10'h001, 1'b0, 8'h00};

        @(negedge clk);
        chk("reset_miso", MISO, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // first frame, then async reset while rx_valid and rx_data are live
        send(10'h0A5, 10'h0A5, 10, 0);
        do_reset();

        for (int k = 0; k < 6; k++) begin
            send(tbl[k].word, tbl[k].exp_rx, 10, 0);
            if (tbl[k].rep) reply(tbl[k].td, tbl[k].exp_miso, tbl[k].dly, 1'b0);
            else noreply();
            end_frame();
        end

        // abort after 5 bits: no strobe, previous word held, next frame clean
        send(10'h155, 10'h155, 10, 0);
        end_frame();
        send(10'h0FF, 10'h0FF, 5, 0);
        end_frame();
        chk("rx_data_hold", rx_data, 10'h155);
        send(10'h001, 10'h001, 10, 0);
        end_frame();

        // read-data aborted before tx_valid keeps the read-address flag
        send(10'h2AA, 10'h2AA, 10, 0);
        end_frame();
        send(10'h311, 10'h311, 10, 0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("miso_abort_wait", MISO, 0);
        end_frame();
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        chk("miso_idle_tx", MISO, 0);
        send(10'h3F0, 10'h3F0, 10, 0);
        reply(8'h5A, 8'h5A, 2, 1'b0);
        end_frame();

        // tx_valid during a write frame is ignored; tx_valid during shifting is ignored
        send(10'h0F0, 10'h0F0, 10, 2);
        noreply();
        end_frame();
        send(10'h200, 10'h200, 10, 0);
        end_frame();
        send(10'h3FF, 10'h3FF, 10, 0);
        reply(8'hC9, 8'hC9, 1, 1'b1);
        end_frame();

        // reset mid-frame clears the read-address flag
        send(10'h2F0, 10'h2F0, 10, 0);
        end_frame();
        send(10'h0F0, 10'h0F0, 4, 0);
        do_reset();
        send(10'h3AB, 10'h3AB, 10, 0);
        noreply();
        end_frame();

        // randomized frames against a frame-level model of the read handshake
        do_reset();
        seen = 1'b0;
        for (int r = 0; r < 60; r++) begin
            logic [9:0] w;
            logic [7:0] td;
            w = 10'($urandom);
            td = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send(w, w, $urandom_range(1, 9), 1);
            end else begin
                send(w, w, 10, 1);
                if (!w[9]) begin
                    noreply();
                end else if (!seen) begin
                    seen = 1'b1;
                    noreply();
                end else if ($urandom_range(0, 3) == 0) begin
                    step(1'b0, 1'b0, 1'b0, 8'h00);
                    chk("miso_wait_rand", MISO, 0);
                end else begin
                    reply(td, td, $urandom_range(1, 4), 1'b1);
                    seen = 1'b0;
                end
            end
            end_frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
